// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin packet arbiter driving a one-hot output-mux select.
// A port is locked from HEAD to TAIL; grants are qualified by downstream ready.
module mux_arbiter #(
  parameter int               NIN     = 2,
  parameter int               TYPEW   = 2,
  parameter logic [TYPEW-1:0] T_NONE  = 2'b00,
  parameter logic [TYPEW-1:0] T_HEAD  = 2'b01,
  parameter logic [TYPEW-1:0] T_TAIL  = 2'b10,
  parameter logic [TYPEW-1:0] T_DATA  = 2'b11,
  parameter int               TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [NIN-1:0]       ivalid,
  input  logic [TYPEW*NIN-1:0] itype,
  input  logic                 ordy,
  output logic [NIN-1:0]       sel,
  output logic                 olock,
  output logic [NIN-1:0]       ogrant,
  output logic                 err_timeout,
  output logic                 err_proto
);

  localparam int PW    = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {
    S_IDLE,
    S_LOCK
  } state_t;

  state_t           state_q, state_d;
  logic [NIN-1:0]   sel_q, sel_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             started_q, started_d;
  logic             err_to_q, err_to_d;
  logic             err_pr_q, err_pr_d;

  logic [TYPEW-1:0] typ [NIN];
  logic [NIN-1:0]   cand;
  logic [NIN-1:0]   fire;
  logic [TYPEW-1:0] lock_type;
  logic             lk_head, lk_tail;
  logic             any_fire, tail_fire;
  logic             excl;
  logic             win_ok;
  logic [PW-1:0]    win;

  for (genvar k = 0; k < NIN; k++) begin : g_port
    assign typ[k]  = itype[k*TYPEW +: TYPEW];
    assign cand[k] = ivalid[k] && (typ[k] == T_HEAD);
  end

  assign fire      = sel_q & ivalid & {NIN{ordy}};
  assign any_fire  = |fire;
  assign lock_type = typ[ptr_q];

  always_comb begin
    lk_head = 1'b0;
    lk_tail = 1'b0;
    case (lock_type)
      T_HEAD:         lk_head = 1'b1;
      T_TAIL:         lk_tail = 1'b1;
      T_DATA, T_NONE: ;
      default:        ;
    endcase
  end

  assign tail_fire = any_fire && lk_tail;

  // While locked, the locked port (== ptr) may not re-win at its own tail.
  assign excl = (state_q == S_LOCK);

  always_comb begin
    logic [PW-1:0] j;
    win_ok = 1'b0;
    win    = ptr_q;
    j      = ptr_q;
    for (int i = 1; i <= NIN; i++) begin
      j = PW'((int'(ptr_q) + i) % NIN);
      if (!win_ok && cand[j] && !(excl && j == ptr_q)) begin
        win_ok = 1'b1;
        win    = j;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    err_to_d  = err_to_q;
    err_pr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_ok) begin
          state_d   = S_LOCK;
          sel_d     = NIN'(1) << win;
          ptr_d     = win;
          cnt_d     = '0;
          started_d = 1'b0;
        end
      end
      S_LOCK: begin
        if (tail_fire) begin
          cnt_d     = '0;
          started_d = 1'b0;
          if (win_ok) begin
            sel_d = NIN'(1) << win;
            ptr_d = win;
          end else begin
            state_d = S_IDLE;
            sel_d   = '0;
          end
        end else if (any_fire) begin
          // First HEAD of a packet is legal; a later one is a protocol slip.
          cnt_d     = '0;
          started_d = 1'b1;
          err_pr_d  = lk_head && started_q;
        end else if (TIMEOUT > 0 && cnt_q == CW'(TLAST)) begin
          state_d  = S_IDLE;
          sel_d    = '0;
          cnt_d    = '0;
          err_to_d = 1'b1;
        end else if (TIMEOUT > 0 && cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      ptr_q     <= PW'(NIN - 1);
      cnt_q     <= '0;
      started_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_pr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      err_to_q  <= err_to_d;
      err_pr_q  <= err_pr_d;
    end
  end

  assign sel         = sel_q;
  assign olock       = |sel_q;
  assign ogrant      = fire;
  assign err_timeout = err_to_q;
  assign err_proto   = err_pr_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed scenarios plus randomized packet traffic,
// checked against a packet-level reference model of the arbiter.
module tb_mux_arbiter;

  localparam int NIN = 2;
  localparam logic [1:0] TN = 2'b00;
  localparam logic [1:0] TH = 2'b01;
  localparam logic [1:0] TT = 2'b10;
  localparam logic [1:0] TD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_;
  logic [1:0] ivalid;
  logic [3:0] itype;
  logic       ordy;
  logic [1:0] sel;
  logic       olock;
  logic [1:0] ogrant;
  logic       err_timeout;
  logic       err_proto;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.NIN(2), .TYPEW(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst_(rst_), .ivalid(ivalid), .itype(itype), .ordy(ordy),
    .sel(sel), .olock(olock), .ogrant(ogrant),
    .err_timeout(err_timeout), .err_proto(err_proto)
  );

  // Reference model: which port owns the output, rotating priority, stalls.
  int m_lock;
  int m_ptr;
  int m_stall;
  bit m_started;
  bit m_et;
  bit m_ep;

  // Upstream packet sources
  bit s_act [NIN];
  int s_pos [NIN];
  int s_len [NIN];

  function automatic void model_reset();
    m_lock = -1; m_ptr = NIN - 1; m_stall = 0;
    m_started = 0; m_et = 0; m_ep = 0;
  endfunction

  function automatic logic [1:0] ftype(int k);
    return itype[k*2 +: 2];
  endfunction

  function automatic logic [1:0] exp_sel();
    return (m_lock < 0) ? 2'b00 : 2'(1 << m_lock);
  endfunction

  function automatic logic [1:0] exp_grant();
    if (m_lock >= 0 && ivalid[m_lock] === 1'b1 && ordy === 1'b1)
      return 2'(1 << m_lock);
    return 2'b00;
  endfunction

  function automatic int pick(int skip);
    for (int i = 1; i <= NIN; i++) begin
      int p;
      p = (m_ptr + i) % NIN;
      if (p != skip && ivalid[p] === 1'b1 && ftype(p) == TH) return p;
    end
    return -1;
  endfunction

  function automatic void model_step();
    bit fire;
    int w;
    m_ep = 0;
    fire = (exp_grant() != 2'b00);
    if (m_lock < 0) begin
      w = pick(-1);
      if (w >= 0) begin
        m_lock = w; m_ptr = w; m_stall = 0; m_started = 0;
      end
    end else if (fire && ftype(m_lock) == TT) begin
      w = pick(m_lock);
      m_lock = w;
      if (w >= 0) m_ptr = w;
      m_stall = 0; m_started = 0;
    end else if (fire) begin
      if (ftype(m_lock) == TH && m_started) m_ep = 1;
      m_started = 1; m_stall = 0;
    end else begin
      m_stall++;
      if (m_stall == 64) begin
        m_lock = -1; m_et = 1; m_stall = 0;
      end
    end
  endfunction

  function automatic void put(int k, bit v, logic [1:0] t);
    ivalid[k] = v;
    itype[k*2 +: 2] = t;
  endfunction

  function automatic void src_clear();
    for (int k = 0; k < NIN; k++) begin
      s_act[k] = 0; s_pos[k] = 0; s_len[k] = 0;
    end
  endfunction

  function automatic void src_drive(int busy, int gap, int lmin, int lmax, int bad);
    for (int k = 0; k < NIN; k++) begin
      logic [1:0] t;
      if (!s_act[k] && $urandom_range(99) < busy) begin
        s_act[k] = 1; s_pos[k] = 0; s_len[k] = $urandom_range(lmax, lmin);
      end
      if (s_act[k] && $urandom_range(99) >= gap) begin
        t = (s_pos[k] == 0) ? TH : (s_pos[k] == s_len[k] - 1) ? TT : TD;
        if (t == TD && $urandom_range(99) < bad) t = TH;
        put(k, 1'b1, t);
      end else begin
        put(k, 1'b0, 2'($urandom_range(3)));
      end
    end
  endfunction

  function automatic void src_adv();
    logic [1:0] g;
    g = exp_grant();
    for (int k = 0; k < NIN; k++) begin
      if (g[k]) begin
        s_pos[k]++;
        if (s_pos[k] == s_len[k]) s_act[k] = 0;
      end
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0; ivalid = '0; itype = '0; ordy = 1'b1;
    model_reset();
    src_clear();
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({sel, olock, ogrant, err_timeout, err_proto} !== 7'b0) begin
      errs++;
      $display("FAIL reset_init: got %b want 0000000",
               {sel, olock, ogrant, err_timeout, err_proto});
    end
    do_reset();
    put(0, 1'b1, TH); put(1, 1'b0, TN);
    step(); step();
    checks++;
    if (sel !== 2'b01) begin
      errs++; $display("FAIL reset_pre_sel: got %b want 01", sel);
    end
    rst_ = 1'b0;
    #1;
    checks++;
    if ({sel, olock, ogrant, err_timeout, err_proto} !== 7'b0) begin
      errs++;
      $display("FAIL reset_async: got %b want 0000000",
               {sel, olock, ogrant, err_timeout, err_proto});
    end
    model_reset();
    put(0, 1'b0, TN);
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sel !== 2'b00 || olock !== 1'b0) begin
      errs++; $display("FAIL reset_release: sel %b olock %b want 00 0", sel, olock);
    end
  endtask

  task automatic test_single_packet();
    int ng;
    do_reset();
    put(1, 1'b1, TH); put(0, 1'b0, TN);
    #1;
    checks++;
    if (sel !== 2'b00 || ogrant !== 2'b00) begin
      errs++; $display("FAIL single_t0: sel %b ogrant %b want 00 00", sel, ogrant);
    end
    step();
    ng = 0;
    for (int i = 0; i < 22; i++) begin
      put(1, 1'b1, (i == 0) ? TH : (i == 21) ? TT : TD);
      #1;
      checks++;
      if (sel !== 2'b10) begin
        errs++; $display("FAIL single_sel[%0d]: got %b want 10", i, sel);
      end
      if (ogrant === 2'b10) ng++;
      step();
    end
    checks++;
    if (ng != 22) begin
      errs++; $display("FAIL single_grants: got %0d want 22", ng);
    end
    put(1, 1'b0, TN);
    #1;
    checks++;
    if (sel !== 2'b00 || olock !== 1'b0) begin
      errs++; $display("FAIL single_release: sel %b olock %b want 00 0", sel, olock);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    put(0, 1'b1, TH); put(1, 1'b1, TH);
    #1; step();
    checks++;
    if (sel !== 2'b01 || ogrant !== 2'b01) begin
      errs++; $display("FAIL simul_first: sel %b ogrant %b want 01 01", sel, ogrant);
    end
    step();
    put(0, 1'b1, TT);
    #1;
    checks++;
    if (ogrant !== 2'b01) begin
      errs++; $display("FAIL simul_tail0: ogrant %b want 01", ogrant);
    end
    step();
    put(0, 1'b0, TN);
    #1;
    checks++;
    if (sel !== 2'b10 || ogrant !== 2'b10) begin
      errs++; $display("FAIL simul_handoff: sel %b ogrant %b want 10 10", sel, ogrant);
    end
    step();
    put(1, 1'b1, TT);
    #1; step();
    put(1, 1'b0, TN);
    #1;
    checks++;
    if (sel !== 2'b00) begin
      errs++; $display("FAIL simul_release: sel %b want 00", sel);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] got [$];
    logic [1:0] want;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      src_drive(100, 0, 3, 3, 0);
      #1;
      for (int k = 0; k < NIN; k++)
        if (ogrant[k] === 1'b1 && ftype(k) == TH) got.push_back(sel);
      src_adv();
      step();
    end
    checks++;
    if (got.size() < 6) begin
      errs++; $display("FAIL fair_count: got %0d packets want >=6", got.size());
    end
    for (int n = 0; n < 6 && n < got.size(); n++) begin
      want = (n % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (got[n] !== want) begin
        errs++; $display("FAIL fair_seq[%0d]: got %b want %b", n, got[n], want);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    put(0, 1'b1, TH); put(1, 1'b0, TN);
    #1; step();
    step();
    put(0, 1'b1, TD); ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ogrant !== 2'b00 || sel !== 2'b01) begin
        errs++; $display("FAIL bp_stall[%0d]: ogrant %b sel %b want 00 01", i, ogrant, sel);
      end
      step();
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (ogrant !== 2'b01) begin
      errs++; $display("FAIL bp_resume: ogrant %b want 01", ogrant);
    end
    step();
    put(0, 1'b1, TT); ordy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; step();
    end
    checks++;
    if (sel !== 2'b01) begin
      errs++; $display("FAIL bp_tail_hold: sel %b want 01", sel);
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (ogrant !== 2'b01) begin
      errs++; $display("FAIL bp_tail_fire: ogrant %b want 01", ogrant);
    end
    step();
    put(0, 1'b0, TN);
    #1;
    checks++;
    if (sel !== 2'b00) begin
      errs++; $display("FAIL bp_release: sel %b want 00", sel);
    end
  endtask

  task automatic test_proto();
    do_reset();
    put(0, 1'b1, TH); put(1, 1'b0, TN);
    #1; step();
    #1; step();
    checks++;
    if (err_proto !== 1'b0) begin
      errs++; $display("FAIL proto_first_head: err_proto %b want 0", err_proto);
    end
    #1; step();
    checks++;
    if (err_proto !== 1'b1 || sel !== 2'b01) begin
      errs++; $display("FAIL proto_pulse: err_proto %b sel %b want 1 01", err_proto, sel);
    end
    put(0, 1'b1, TT);
    #1; step();
    checks++;
    if (err_proto !== 1'b0 || sel !== 2'b00) begin
      errs++; $display("FAIL proto_clear: err_proto %b sel %b want 0 00", err_proto, sel);
    end
    put(0, 1'b0, TN);
  endtask

  task automatic test_timeout();
    do_reset();
    put(0, 1'b1, TH); put(1, 1'b0, TN);
    #1; step();
    #1; step();
    put(0, 1'b0, TN);
    for (int i = 0; i < 63; i++) begin
      #1; step();
    end
    checks++;
    if (sel !== 2'b01 || err_timeout !== 1'b0) begin
      errs++; $display("FAIL to_before: sel %b err_timeout %b want 01 0", sel, err_timeout);
    end
    #1; step();
    checks++;
    if (sel !== 2'b00 || olock !== 1'b0 || err_timeout !== 1'b1) begin
      errs++;
      $display("FAIL to_expire: sel %b olock %b err_timeout %b want 00 0 1",
               sel, olock, err_timeout);
    end
    put(0, 1'b1, TH);
    #1; step();
    checks++;
    if (sel !== 2'b01 || err_timeout !== 1'b1) begin
      errs++; $display("FAIL to_regrant: sel %b err_timeout %b want 01 1", sel, err_timeout);
    end
    #1; step();
    put(0, 1'b1, TT);
    #1;
    checks++;
    if (ogrant !== 2'b01) begin
      errs++; $display("FAIL to_tail: ogrant %b want 01", ogrant);
    end
    step();
    put(0, 1'b0, TN);
  endtask

  task automatic test_random();
    logic [6:0] got, want;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      src_drive(40, 20, 2, 6, 5);
      ordy = ($urandom_range(99) < 80);
      #1;
      got  = {sel, olock, ogrant, err_timeout, err_proto};
      want = {exp_sel(), m_lock >= 0, exp_grant(), m_et, m_ep};
      checks++;
      if (got !== want || $countones(sel) > 1) begin
        errs++;
        $display("FAIL random[%0d]: {sel,olock,ogrant,eto,epr} got %b want %b", c, got, want);
      end
      src_adv();
      step();
    end
  endtask

  initial begin
    rst_ = 1'b0; ivalid = '0; itype = '0; ordy = 1'b0;
    model_reset();
    src_clear();
    #12;
    test_reset();
    test_single_packet();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_proto();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
